// File: rtl/dest_hazard_tracker.sv
// ============================================================================
// Module  : dest_hazard_tracker
// Brief   : X/M/W destination tracking, W-stage regfile write port, and decode
//           stall for load-use, RAW and pending mult/div hazards.
//           Optional macro HAZARD_BYPASS_EN adds fwd_a/fwd_b forwarding selects.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dest_hazard_tracker #(
    parameter int ADDR_W     = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [ADDR_W-1:0] d_rd,
    input  logic              d_we,
    input  logic              d_is_load,
    input  logic              d_is_md,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic              d_rs_used,
    input  logic              d_rt_used,
    input  logic              flush,
    input  logic              md_ready,
    output logic              stall,
    output logic [ADDR_W-1:0] w_rd,
    output logic              w_we,
    output logic              md_busy,
    output logic [ADDR_W-1:0] md_rd,
`ifdef HAZARD_BYPASS_EN
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
`endif
    output logic              md_timeout
);

    localparam int              CNT_W   = $clog2(MD_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT);

    // Pipeline tracking entries; the load flag only matters in X.
    logic [ADDR_W-1:0] x_rd;
    logic              x_we;
    logic              x_load;
    logic [ADDR_W-1:0] m_rd;
    logic              m_we;
    logic [CNT_W-1:0]  md_cnt;

    logic              eff_we;
    logic              issue;
    logic              match_x;
    logic              match_m;
    logic              match_md;
    logic              load_use;
    logic              md_hazard;
    logic              raw_hazard;

    assign eff_we = d_valid & d_we & (d_rd != '0);
    assign issue  = d_valid & ~stall & ~flush;

    assign match_x  = (x_rd != '0) &
                      ((d_rs_used & (d_rs == x_rd)) | (d_rt_used & (d_rt == x_rd)));
    assign match_m  = (m_rd != '0) &
                      ((d_rs_used & (d_rs == m_rd)) | (d_rt_used & (d_rt == m_rd)));
    assign match_md = (md_rd != '0) &
                      ((d_rs_used & (d_rs == md_rd)) | (d_rt_used & (d_rt == md_rd)));

    assign load_use  = x_load & x_we & match_x;
    assign md_hazard = md_busy & (match_md | (d_we & (d_rd == md_rd)) | d_is_md);

`ifdef HAZARD_BYPASS_EN
    // Non-load producers in X or M are forwarded, so only load-use stalls.
    assign raw_hazard = 1'b0;

    always_comb begin
        fwd_a = 2'b00;
        if (x_we & ~x_load & d_rs_used & (d_rs == x_rd) & (d_rs != '0))
            fwd_a = 2'b01;
        else if (m_we & d_rs_used & (d_rs == m_rd) & (d_rs != '0))
            fwd_a = 2'b10;
    end

    always_comb begin
        fwd_b = 2'b00;
        if (x_we & ~x_load & d_rt_used & (d_rt == x_rd) & (d_rt != '0))
            fwd_b = 2'b01;
        else if (m_we & d_rt_used & (d_rt == m_rd) & (d_rt != '0))
            fwd_b = 2'b10;
    end
`else
    // Without bypass any in-flight producer in X or M blocks the reader.
    assign raw_hazard = (x_we & match_x) | (m_we & match_m);
`endif

    assign stall = d_valid & ~flush & (load_use | md_hazard | raw_hazard);

    always_ff @(posedge clock) begin
        if (reset) begin
            x_rd       <= '0;
            x_we       <= 1'b0;
            x_load     <= 1'b0;
            m_rd       <= '0;
            m_we       <= 1'b0;
            w_rd       <= '0;
            w_we       <= 1'b0;
            md_busy    <= 1'b0;
            md_rd      <= '0;
            md_cnt     <= '0;
            md_timeout <= 1'b0;
        end else begin
            w_rd <= m_rd;
            w_we <= m_we;
            m_rd <= x_rd;
            m_we <= x_we;

            if (issue) begin
                x_rd   <= d_rd;
                x_we   <= eff_we & ~d_is_md;
                x_load <= d_is_load;
            end else begin
                x_rd   <= '0;
                x_we   <= 1'b0;
                x_load <= 1'b0;
            end

            if (md_busy) begin
                if (md_ready) begin
                    md_busy <= 1'b0;
                end else if (md_cnt != CNT_MAX) begin
                    md_cnt <= md_cnt + CNT_W'(1);
                    if (md_cnt + CNT_W'(1) == CNT_MAX)
                        md_timeout <= 1'b1;
                end
            end

            // A new mult/div can only issue once the previous one has retired.
            if (issue & d_is_md) begin
                md_busy <= 1'b1;
                md_rd   <= d_rd;
                md_cnt  <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dest_hazard_tracker.sv
// ============================================================================
// Module  : tb_dest_hazard_tracker
// Brief   : Directed and randomized bench for dest_hazard_tracker against a
//           cycle-history reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dest_hazard_tracker;

    localparam int ADDR_W     = 5;
    localparam int MD_TIMEOUT = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              d_valid, d_we, d_is_load, d_is_md;
    logic [ADDR_W-1:0] d_rd, d_rs, d_rt;
    logic              d_rs_used, d_rt_used, flush, md_ready;
    logic              stall, w_we, md_busy, md_timeout;
    logic [ADDR_W-1:0] w_rd, md_rd;
`ifdef HAZARD_BYPASS_EN
    logic [1:0]        fwd_a, fwd_b;
`endif

    dest_hazard_tracker #(.ADDR_W(ADDR_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_rd(d_rd), .d_we(d_we),
        .d_is_load(d_is_load), .d_is_md(d_is_md), .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_used(d_rs_used), .d_rt_used(d_rt_used), .flush(flush),
        .md_ready(md_ready), .stall(stall), .w_rd(w_rd), .w_we(w_we),
        .md_busy(md_busy), .md_rd(md_rd),
`ifdef HAZARD_BYPASS_EN
        .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
        .md_timeout(md_timeout)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the last three issued slots (0 = X, 1 = M, 2 = W)
    // plus the pending mult/div described by its destination and start edge.
    typedef struct {
        int rd;
        bit we;
        bit ld;
    } ent_t;

    ent_t pipe[3];
    bit   m_busy;
    int   m_mdrd;
    int   m_start;
    bit   m_tmo;
    int   edge_no = 0;
    bit   obs_stall;

    function automatic bit hits(int r);
        return (r != 0) && ((d_rs_used && int'(d_rs) == r) || (d_rt_used && int'(d_rt) == r));
    endfunction

    function automatic bit model_stall();
        bit lu, mdh, raw;
        lu  = pipe[0].ld && pipe[0].we && hits(pipe[0].rd);
        mdh = m_busy && (hits(m_mdrd) || (d_we && int'(d_rd) == m_mdrd) || d_is_md);
`ifdef HAZARD_BYPASS_EN
        raw = 1'b0;
`else
        raw = (pipe[0].we && hits(pipe[0].rd)) || (pipe[1].we && hits(pipe[1].rd));
`endif
        return d_valid && !flush && (lu || mdh || raw);
    endfunction

`ifdef HAZARD_BYPASS_EN
    function automatic logic [1:0] model_fwd(int src, bit used);
        if (used && src != 0 && pipe[0].we && !pipe[0].ld && pipe[0].rd == src) return 2'b01;
        if (used && src != 0 && pipe[1].we && pipe[1].rd == src) return 2'b10;
        return 2'b00;
    endfunction
`endif

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 1'b0, 1'b0};
        m_busy = 0; m_mdrd = 0; m_start = 0; m_tmo = 0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic drive_cycle();
        bit   s;
        ent_t e;
        #1;
        s = model_stall();
        obs_stall = stall;
        check("stall", {31'd0, stall}, {31'd0, s});
        check("w_we", {31'd0, w_we}, {31'd0, pipe[2].we});
        check("w_rd", 32'(w_rd), 32'(pipe[2].rd));
        check("md_busy", {31'd0, md_busy}, {31'd0, m_busy});
        if (m_busy) check("md_rd", 32'(md_rd), 32'(m_mdrd));
        check("md_timeout", {31'd0, md_timeout}, {31'd0, m_tmo});
`ifdef HAZARD_BYPASS_EN
        check("fwd_a", 32'(fwd_a), 32'(model_fwd(int'(d_rs), d_rs_used)));
        check("fwd_b", 32'(fwd_b), 32'(model_fwd(int'(d_rt), d_rt_used)));
`endif
        @(posedge clock);
        edge_no++;
        if (reset) begin
            model_reset();
        end else begin
            e = '{0, 1'b0, 1'b0};
            if (d_valid && !s && !flush) begin
                e.rd = int'(d_rd);
                e.we = d_we && d_rd != 0 && !d_is_md;
                e.ld = d_is_load;
            end
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e;
            if (m_busy) begin
                if (md_ready) m_busy = 0;
                else if (edge_no - m_start >= MD_TIMEOUT) m_tmo = 1;
            end
            if (d_valid && !s && !flush && d_is_md) begin
                m_busy = 1; m_mdrd = int'(d_rd); m_start = edge_no;
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 0; d_valid = 0; d_rd = 0; d_we = 0; d_is_load = 0; d_is_md = 0;
        d_rs = 0; d_rt = 0; d_rs_used = 0; d_rt_used = 0; flush = 0; md_ready = 0;
    endtask

    task automatic instr(input int rd, input bit we, input bit ld, input bit md,
                         input int rs, input bit rsu, input int rt, input bit rtu);
        idle();
        d_valid = 1; d_rd = ADDR_W'(rd); d_we = we; d_is_load = ld; d_is_md = md;
        d_rs = ADDR_W'(rs); d_rs_used = rsu; d_rt = ADDR_W'(rt); d_rt_used = rtu;
    endtask

    task automatic do_reset();
        idle(); reset = 1;
        drive_cycle();
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        @(negedge clock);
        do_reset();
        check("rst_w_we", {31'd0, w_we}, 32'd0);
        check("rst_md_busy", {31'd0, md_busy}, 32'd0);
        drive_cycle();

        // add $3 then bubbles: W write appears on the third edge only
        instr(3, 1, 0, 0, 1, 1, 2, 1); drive_cycle();
        idle(); drive_cycle(); drive_cycle();
        check("add_w_we", {31'd0, w_we}, 32'd1);
        check("add_w_rd", 32'(w_rd), 32'd3);
        drive_cycle();
        check("add_w_off", {31'd0, w_we}, 32'd0);

        // lw $5 then reader of $5
        instr(5, 1, 1, 0, 0, 0, 0, 0); drive_cycle();
        instr(6, 1, 0, 0, 5, 1, 0, 0); drive_cycle();
        check("lu_stall", {31'd0, obs_stall}, 32'd1);
        for (int i = 0; i < 4 && obs_stall; i++) drive_cycle();
        idle(); for (int i = 0; i < 4; i++) drive_cycle();

        // mul $7, reader held until the cycle after md_ready
        instr(7, 1, 0, 1, 1, 1, 2, 1); drive_cycle();
        check("mul_busy", {31'd0, md_busy}, 32'd1);
        check("mul_rd", 32'(md_rd), 32'd7);
        instr(8, 1, 0, 0, 7, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drive_cycle();
            check("mul_hold", {31'd0, obs_stall}, 32'd1);
        end
        md_ready = 1; drive_cycle();
        check("mul_rdy_stall", {31'd0, obs_stall}, 32'd1);
        md_ready = 0; drive_cycle();
        check("mul_release", {31'd0, obs_stall}, 32'd0);
        check("mul_idle", {31'd0, md_busy}, 32'd0);
        idle(); for (int i = 0; i < 4; i++) drive_cycle();

        // stall + flush: flush wins, nothing enters
        instr(5, 1, 1, 0, 0, 0, 0, 0); drive_cycle();
        instr(9, 1, 0, 0, 5, 1, 0, 0); flush = 1; drive_cycle();
        check("flush_stall", {31'd0, obs_stall}, 32'd0);
        idle(); drive_cycle();
        check("flush_lw_w", {31'd0, w_we}, 32'd1);
        drive_cycle();
        check("flush_w", {31'd0, w_we}, 32'd0);
        drive_cycle();

        // register zero never writes and never hazards
        instr(0, 1, 0, 0, 0, 0, 0, 0); drive_cycle();
        instr(4, 1, 0, 0, 0, 1, 0, 1); drive_cycle();
        check("zero_stall", {31'd0, obs_stall}, 32'd0);
        idle(); drive_cycle();
        check("zero_w_we", {31'd0, w_we}, 32'd0);
        for (int i = 0; i < 3; i++) drive_cycle();

        // watchdog
        do_reset();
        instr(4, 1, 0, 1, 0, 0, 0, 0); drive_cycle();
        idle();
        for (int i = 0; i < MD_TIMEOUT - 1; i++) drive_cycle();
        check("tmo_before", {31'd0, md_timeout}, 32'd0);
        drive_cycle();
        check("tmo_set", {31'd0, md_timeout}, 32'd1);
        md_ready = 1; drive_cycle();
        md_ready = 0; drive_cycle();
        check("tmo_sticky", {31'd0, md_timeout}, 32'd1);
        do_reset();
        check("tmo_clear", {31'd0, md_timeout}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            instr($urandom_range(0, 7), ($urandom % 4) != 0, ($urandom % 4) == 0,
                  ($urandom % 10) == 0, $urandom_range(0, 7), $urandom % 2,
                  $urandom_range(0, 7), $urandom % 2);
            d_valid  = ($urandom % 4) != 0;
            flush    = ($urandom % 10) == 0;
            md_ready = ($urandom % 8) == 0;
            reset    = ($urandom % 300) == 0;
            drive_cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
